// File: rtl/ps2_command_sequencer.sv
// PS/2 host command sequencer: keyboard reset/BAT handshake, optional set-LEDs command, scan-code filter.
// Define PS2_SEQ_LED_EN to include the LED update path (0xED + argument).
module ps2_command_sequencer #(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int BAT_TIMEOUT = 37_500_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] ps2_data,
    input  logic       ps2_data_en,
    input  logic       cmd_sent,
    input  logic       cmd_timeout,
    output logic [7:0] cmd_data,
    output logic       cmd_send,
    input  logic       led_req,
    input  logic [2:0] led_value,
    output logic       led_done,
    output logic       ready,
    output logic       error,
    output logic [7:0] key_data,
    output logic       key_valid
);

    localparam logic [25:0] ACK_TO    = 26'(ACK_TIMEOUT);
    localparam logic [25:0] BAT_TO    = 26'(BAT_TIMEOUT);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

`ifdef PS2_SEQ_LED_EN
    typedef enum logic [3:0] {
        S_RST_SEND, S_RST_ACK, S_BAT, S_IDLE,
        S_LED_SEND, S_LED_ACK, S_ARG_SEND, S_ARG_ACK, S_ERROR
    } state_t;
`else
    typedef enum logic [3:0] {
        S_RST_SEND, S_RST_ACK, S_BAT, S_IDLE, S_ERROR
    } state_t;
`endif

    state_t      state_q, state_d, retry_state;
    logic [7:0]  retry_q, retry_d;
    logic [25:0] wait_q, wait_d, wait_inc;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        cmd_send_q, cmd_send_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic [7:0]  key_data_q, key_data_d;
    logic        key_valid_q, key_valid_d;
    logic        fail;
    logic        byte_fa, byte_fe, byte_aa, byte_fc;

`ifdef PS2_SEQ_LED_EN
    logic [2:0]  led_val_q, led_val_d;
    logic        led_done_q, led_done_d;
`else
    logic        unused_led;
    assign unused_led = &{1'b0, led_req, led_value};
`endif

    assign byte_fa  = ps2_data_en && (ps2_data == 8'hFA);
    assign byte_fe  = ps2_data_en && (ps2_data == 8'hFE);
    assign byte_aa  = ps2_data_en && (ps2_data == 8'hAA);
    assign byte_fc  = ps2_data_en && (ps2_data == 8'hFC);
    assign wait_inc = (wait_q == 26'h3FF_FFFF) ? wait_q : wait_q + 26'd1;

    always_comb begin
        state_d     = state_q;
        retry_state = state_q;
        retry_d     = retry_q;
        wait_d      = wait_q;
        cmd_data_d  = cmd_data_q;
        cmd_send_d  = 1'b0;
        key_data_d  = key_data_q;
        key_valid_d = 1'b0;
        fail        = 1'b0;
`ifdef PS2_SEQ_LED_EN
        led_val_d   = led_val_q;
        led_done_d  = 1'b0;
`endif
        case (state_q)
            S_RST_SEND: begin
                cmd_data_d = 8'hFF;
                if (cmd_sent) state_d = S_RST_ACK;
                else if (cmd_timeout) begin
                    fail        = 1'b1;
                    retry_state = S_RST_SEND;
                end else cmd_send_d = 1'b1;
            end
            S_RST_ACK: begin
                if (byte_fa) begin
                    retry_d = 8'd0;
                    state_d = S_BAT;
                end else if (byte_fe || wait_q >= ACK_TO) begin
                    fail        = 1'b1;
                    retry_state = S_RST_SEND;
                end else wait_d = wait_inc;
            end
            // A failed self-test counts against the reset command, so retry resends 0xFF.
            S_BAT: begin
                if (byte_aa) state_d = S_IDLE;
                else if (byte_fc || wait_q >= BAT_TO) begin
                    fail        = 1'b1;
                    retry_state = S_RST_SEND;
                end else wait_d = wait_inc;
            end
            S_IDLE: begin
                if (ps2_data_en) begin
                    key_valid_d = 1'b1;
                    key_data_d  = ps2_data;
                end
`ifdef PS2_SEQ_LED_EN
                if (led_req) begin
                    led_val_d = led_value;
                    state_d   = S_LED_SEND;
                end
`endif
            end
`ifdef PS2_SEQ_LED_EN
            S_LED_SEND: begin
                cmd_data_d = 8'hED;
                if (cmd_sent) state_d = S_LED_ACK;
                else if (cmd_timeout) begin
                    fail        = 1'b1;
                    retry_state = S_LED_SEND;
                end else cmd_send_d = 1'b1;
            end
            S_LED_ACK: begin
                if (byte_fa) begin
                    retry_d = 8'd0;
                    state_d = S_ARG_SEND;
                end else if (byte_fe || wait_q >= ACK_TO) begin
                    fail        = 1'b1;
                    retry_state = S_LED_SEND;
                end else wait_d = wait_inc;
            end
            S_ARG_SEND: begin
                cmd_data_d = {5'b0, led_val_q};
                if (cmd_sent) state_d = S_ARG_ACK;
                else if (cmd_timeout) begin
                    fail        = 1'b1;
                    retry_state = S_ARG_SEND;
                end else cmd_send_d = 1'b1;
            end
            S_ARG_ACK: begin
                if (byte_fa) begin
                    retry_d    = 8'd0;
                    state_d    = S_IDLE;
                    led_done_d = 1'b1;
                end else if (byte_fe || wait_q >= ACK_TO) begin
                    fail        = 1'b1;
                    retry_state = S_ARG_SEND;
                end else wait_d = wait_inc;
            end
`endif
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase

        if (fail) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 8'd1;
                state_d = retry_state;
            end else state_d = S_ERROR;
        end
        if (state_d != state_q) wait_d = 26'd0;

        ready_d = (state_d == S_IDLE);
        error_d = error_q | (state_d == S_ERROR);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_RST_SEND;
            retry_q     <= 8'd0;
            wait_q      <= 26'd0;
            cmd_data_q  <= 8'h00;
            cmd_send_q  <= 1'b0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            key_data_q  <= 8'h00;
            key_valid_q <= 1'b0;
`ifdef PS2_SEQ_LED_EN
            led_val_q   <= 3'b000;
            led_done_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            wait_q      <= wait_d;
            cmd_data_q  <= cmd_data_d;
            cmd_send_q  <= cmd_send_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            key_data_q  <= key_data_d;
            key_valid_q <= key_valid_d;
`ifdef PS2_SEQ_LED_EN
            led_val_q   <= led_val_d;
            led_done_q  <= led_done_d;
`endif
        end
    end

    assign cmd_data  = cmd_data_q;
    assign cmd_send  = cmd_send_q;
    assign ready     = ready_q;
    assign error     = error_q;
    assign key_data  = key_data_q;
    assign key_valid = key_valid_q;
`ifdef PS2_SEQ_LED_EN
    assign led_done  = led_done_q;
`else
    assign led_done  = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_command_sequencer.sv
// Directed bench for ps2_command_sequencer: reset handshake, byte forwarding, LED path (when
// PS2_SEQ_LED_EN is defined), retry-to-error and asynchronous reset mid-command.
module tb_ps2_command_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ps2_data;
    logic       ps2_data_en, cmd_sent, cmd_timeout, led_req;
    logic [2:0] led_value;
    logic [7:0] cmd_data, key_data;
    logic       cmd_send, led_done, ready, error, key_valid;

    int checks = 0;
    int errors = 0;

    ps2_command_sequencer #(.ACK_TIMEOUT(50), .BAT_TIMEOUT(200), .MAX_RETRY(3)) dut (
        .CLOCK_50(clk), .reset(rst), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
        .cmd_sent(cmd_sent), .cmd_timeout(cmd_timeout), .cmd_data(cmd_data), .cmd_send(cmd_send),
        .led_req(led_req), .led_value(led_value), .led_done(led_done), .ready(ready),
        .error(error), .key_data(key_data), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cmd_send"}, 32'(cmd_send), 32'd0);
        chk({tag, " cmd_data"}, 32'(cmd_data), 32'h00);
        chk({tag, " led_done"}, 32'(led_done), 32'd0);
        chk({tag, " ready"}, 32'(ready), 32'd0);
        chk({tag, " error"}, 32'(error), 32'd0);
        chk({tag, " key_data"}, 32'(key_data), 32'h00);
        chk({tag, " key_valid"}, 32'(key_valid), 32'd0);
    endtask

    task automatic pulse_sent();
        cmd_sent = 1'b1;
        tick();
        cmd_sent = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        tick();
        ps2_data_en = 1'b0;
    endtask

    task automatic wait_send(input string name);
        int n = 0;
        while (!cmd_send && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(cmd_send), 32'd1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'hE0, 1'b1, 8'hE0};
        vecs[1] = '{1'b1, 8'h75, 1'b1, 8'h75};
        vecs[2] = '{1'b0, 8'h33, 1'b0, 8'h75};
        vecs[3] = '{1'b1, 8'hF0, 1'b1, 8'hF0};
        vecs[4] = '{1'b1, 8'h1C, 1'b1, 8'h1C};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 8'h1C};

        rst = 1'b1; ps2_data = 8'h00; ps2_data_en = 1'b0; cmd_sent = 1'b0;
        cmd_timeout = 1'b0; led_req = 1'b0; led_value = 3'b000;
        repeat (3) tick();
        chk_reset_outputs("reset");

        // Power-up handshake: 0xFF, ACK, BAT pass.
        rst = 1'b0;
        tick();
        chk("rst cmd_send", 32'(cmd_send), 32'd1);
        chk("rst cmd_data", 32'(cmd_data), 32'hFF);
        pulse_sent();
        chk("rst cmd_send drop", 32'(cmd_send), 32'd0);
        send_byte(8'hFA);
        chk("ack not fwd", 32'(key_valid), 32'd0);
        chk("ack ready low", 32'(ready), 32'd0);
        send_byte(8'hAA);
        chk("bat not fwd", 32'(key_valid), 32'd0);
        chk("bat ready", 32'(ready), 32'd1);
        tick();
        chk("bat not fwd late", 32'(key_valid), 32'd0);

        for (int i = 0; i < 6; i++) begin
            ps2_data    = vecs[i].data;
            ps2_data_en = vecs[i].en;
            tick();
            chk($sformatf("fwd[%0d] valid", i), 32'(key_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("fwd[%0d] data", i), 32'(key_data), 32'(vecs[i].exp_data));
        end
        ps2_data_en = 1'b0;

`ifdef PS2_SEQ_LED_EN
        led_req = 1'b1; led_value = 3'b101;
        tick();
        chk("led accept ready", 32'(ready), 32'd0);
        led_value = 3'b000;
        tick();
        chk("led cmd_send", 32'(cmd_send), 32'd1);
        chk("led cmd_data", 32'(cmd_data), 32'hED);
        pulse_sent();
        send_byte(8'hFA);
        tick();
        chk("arg cmd_send", 32'(cmd_send), 32'd1);
        chk("arg cmd_data", 32'(cmd_data), 32'h05);
        pulse_sent();
        send_byte(8'hFE);
        chk("arg nak no done", 32'(led_done), 32'd0);
        tick();
        chk("arg resend send", 32'(cmd_send), 32'd1);
        chk("arg resend data", 32'(cmd_data), 32'h05);
        pulse_sent();
        send_byte(8'hFA);
        chk("led_done", 32'(led_done), 32'd1);
        chk("led ready", 32'(ready), 32'd1);
        chk("led ack not fwd", 32'(key_valid), 32'd0);
        led_req = 1'b0;
        tick();
        chk("led_done single", 32'(led_done), 32'd0);

        // Reset while the argument byte is being requested.
        led_req = 1'b1; led_value = 3'b010;
        tick();
        tick();
        pulse_sent();
        send_byte(8'hFA);
        led_req = 1'b0;
        tick();
        chk("mid arg send", 32'(cmd_send), 32'd1);
        chk("mid arg data", 32'(cmd_data), 32'h02);
`else
        led_req = 1'b1; led_value = 3'b101;
        repeat (3) tick();
        chk("noled ready", 32'(ready), 32'd1);
        chk("noled done", 32'(led_done), 32'd0);
        chk("noled cmd_send", 32'(cmd_send), 32'd0);
        led_req = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ps2_data = 8'h5A; ps2_data_en = 1'b1;
        tick();
        ps2_data_en = 1'b0;
        chk("mid rst send", 32'(cmd_send), 32'd1);
        chk("mid rst no fwd", 32'(key_valid), 32'd0);
`endif
        // Asynchronous reset mid-command: outputs clear without waiting for a clock edge.
        rst = 1'b1;
        #1;
        chk_reset_outputs("async");
        tick();
        rst = 1'b0;
        tick();
        chk("restart cmd_send", 32'(cmd_send), 32'd1);
        chk("restart cmd_data", 32'(cmd_data), 32'hFF);

        // No ACK for four attempts: three retries then error.
        for (int a = 0; a < 4; a++) begin
            wait_send($sformatf("retry[%0d] send", a));
            chk($sformatf("retry[%0d] data", a), 32'(cmd_data), 32'hFF);
            chk($sformatf("retry[%0d] no err", a), 32'(error), 32'd0);
            pulse_sent();
        end
        begin
            int n = 0;
            while (!error && n < 200) begin
                tick();
                n++;
            end
        end
        chk("err set", 32'(error), 32'd1);
        chk("err ready", 32'(ready), 32'd0);
        send_byte(8'h1C);
        chk("err no fwd", 32'(key_valid), 32'd0);
        repeat (60) tick();
        chk("err sticky", 32'(error), 32'd1);
        chk("err no resend", 32'(cmd_send), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_command_sequencer.md
# ps2_command_sequencer

Sequences host-to-keyboard traffic on the PS/2 controller and filters the received byte stream. After reset it sends the keyboard reset command (0xFF) and waits for ACK (0xFA) and BAT pass (0xAA). On request it sends set-LEDs (0xED plus argument) with retry and timeout handling. It forwards only ordinary scan-code bytes to the keyboard decoder, so protocol bytes never reach game logic.

## Interface
- `ACK_TIMEOUT`, 1_000_000: cycles to wait for 0xFA after `cmd_sent` (20 ms at 50 MHz).
- `BAT_TIMEOUT`, 37_500_000: cycles to wait for 0xAA after reset ACK (750 ms).
- `MAX_RETRY`, 3: resend attempts per command byte before entering error.
- `CLOCK_50`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_data`  in  8  received byte from PS2_Controller `received_data`.
- `ps2_data_en`  in  1  one-cycle strobe qualifying `ps2_data`.
- `cmd_sent`  in  1  PS2_Controller `command_was_sent` pulse.
- `cmd_timeout`  in  1  PS2_Controller `error_communication_timed_out` pulse.
- `cmd_data`  out  8  byte to transmit (`the_command`).
- `cmd_send`  out  1  transmit request (`send_command`).
- `led_req`  in  1  LED update request; held by requester until `led_done`.
- `led_value`  in  3  {caps, num, scroll}; sampled when the request is accepted.
- `led_done`  out  1  one-cycle pulse when the LED argument is ACKed.
- `ready`  out  1  high in S_IDLE only.
- `error`  out  1  sticky until reset; high in S_ERROR.
- `key_data`  out  8  forwarded scan-code byte.
- `key_valid`  out  1  one-cycle strobe qualifying `key_data`.

## Operation
- States: S_RST_SEND, S_RST_ACK, S_BAT, S_IDLE, S_LED_SEND, S_LED_ACK, S_ARG_SEND, S_ARG_ACK, S_ERROR.
- `*_SEND` states:
  - `cmd_send`=1, with `cmd_data` = 0xFF / 0xED / {5'b0, latched led_value}.
  - `cmd_sent` moves to the matching `*_ACK` state and clears the wait counter.
  - `cmd_timeout` counts as a failed attempt.
- `*_ACK` states:
  - Byte 0xFA: success. Clear the retry count and advance: RST_ACK→BAT, LED_ACK→ARG_SEND, ARG_ACK→IDLE with `led_done`.
  - Byte 0xFE, or counter reaching ACK_TIMEOUT: failed attempt. Any other byte is ignored.
- Failed attempt:
  - If retry count < MAX_RETRY: increment the count and return to the same `*_SEND`.
  - Otherwise go to S_ERROR.
  - A failure in S_ARG_ACK resends the argument only, not 0xED.
- S_BAT:
  - 0xAA goes to S_IDLE.
  - 0xFC or BAT_TIMEOUT counts as a failed attempt of the reset command; a retry resends 0xFF.
- S_IDLE:
  - Every `ps2_data_en` byte is forwarded.
  - `led_req`=1 latches `led_value` and goes to S_LED_SEND.
- S_ERROR: absorbing until `reset`. Bytes are not forwarded and `led_req` is ignored.
- Bytes that arrive in any non-idle state are consumed and never forwarded.
- Wait counter: 26 bits, saturating, and incremented only in ACK/BAT states.

## Timing
- Reset values:
  - State S_RST_SEND; retry count and wait counter 0.
  - `cmd_send`=0, `cmd_data`=0x00, `led_done`=0, `ready`=0, `error`=0, `key_data`=0x00, `key_valid`=0.
- `cmd_send` is registered:
  - It rises one cycle after entering a SEND state.
  - It falls the cycle after `cmd_sent` or `cmd_timeout`.
  - `cmd_data` is stable while `cmd_send`=1.
- Forwarding latency is one cycle: `ps2_data_en` at edge N gives `key_valid`=1 and `key_data` at edge N+1.
- `led_done` and the transition to `ready`=1 occur in the same cycle.
- A requester must see `led_done` before it drops `led_req`; a re-asserted `led_req` is accepted the cycle after `ready` returns.
- Simultaneous `ps2_data_en` and `led_req` in S_IDLE: the byte is forwarded and the request is accepted in the same cycle.
- `cmd_sent` and 0xFA in the same cycle in a SEND state: the 0xFA is ignored and the sequencer waits in ACK. The controller never produces this case.
- Asserting `reset` mid-command returns all outputs to reset values immediately, abandons the transfer, and restarts from S_RST_SEND after deassertion.

## Configuration
- `PS2_SEQ_LED_EN` defined: the LED path and states are present as described.
- Not defined:
  - The LED states are omitted and `led_req`/`led_value` are ignored.
  - `led_done` is tied to 0.
  - The sequencer performs only the reset/BAT handshake and then forwards bytes.

## Test plan
- Reset with ACK_TIMEOUT=50 and BAT_TIMEOUT=200; on `cmd_sent`, inject 0xFA then 0xAA. Required: `cmd_data`=0xFF, then `ready`=1, with `key_valid` never asserted for either byte.
- In idle, inject 0xE0, 0x75, 0xF0. Required: three `key_valid` pulses, each one cycle after its strobe, carrying the same bytes.
- With `led_req`=1 and `led_value`=3'b101: ACK 0xED, then ACK the argument. Required: `cmd_data` sequence 0xED, 0x05, then a single `led_done` pulse.
- During the argument ACK, inject 0xFE, then 0xFA. Required: 0x05 is resent (not 0xED), then `led_done`.
- Give no ACK for four attempts with MAX_RETRY=3. Required: `error`=1 and `ready`=0 after the fourth timeout; later bytes are not forwarded.
- Assert `reset` while `cmd_send`=1 in S_ARG_SEND. Required: all outputs return to reset values that cycle, and `cmd_data`=0xFF after release.
